fifo_wr_arbiter: RTL
====================

Name: fifo_wr_arbiter

Overview:
- Write-side scheduler for the asynchronous FIFO. Shares the FIFO's single write port among NUM_REQ requesters using round-robin burst arbitration.
- Lives entirely in the FIFO write-clock domain. Drives the FIFO write strobe and data directly, and throttles on the FIFO's active-low full flag.
- Bursts end on packet boundary (last), on the burst-length cap, or when the granted requester withdraws. This bounds latency for the other requesters.

Parameters:
NUM_REQ, 4, number of requesters (2..16)
DATA_WIDTH, 18, word width, matches the FIFO data_in width
MAX_BURST, 16, max words per grant (power of two, >=2)

Ports:
clk_wr_i  input  1  write clock, same as FIFO clk_wr_i; single clock, rising edge
mrst_n_i  input  1  asynchronous active-low reset
arb_en_i  input  1  1 = new grants allowed; 0 = finish current burst, then park in IDLE
req_valid_i  input  NUM_REQ  per-requester word valid
req_last_i  input  NUM_REQ  per-requester last word of packet, qualified by valid
req_data_i  input  NUM_REQ*DATA_WIDTH  packed data, requester k at [k*DATA_WIDTH +: DATA_WIDTH]
req_ready_o  output  NUM_REQ  per-requester ready, one-hot or zero
fifo_full_n_i  input  1  FIFO full flag, active-low (0 = full, no space)
fifo_wr_o  output  1  FIFO write strobe
fifo_data_o  output  DATA_WIDTH  FIFO write data
grant_o  output  NUM_REQ  one-hot current owner, 0 in IDLE
busy_o  output  1  1 while in BURST
word_cnt_o  output  16  total words written since reset, saturating at 0xFFFF

Behaviour:
Reset (mrst_n_i low, asynchronous), all outputs at these values immediately:
- state=IDLE, grant_o=0, req_ready_o=0, fifo_wr_o=0, fifo_data_o=0, busy_o=0, word_cnt_o=0.
- Burst counter = 0. Round-robin pointer last_idx = NUM_REQ-1, so requester 0 has first priority.
- Reset asserted mid-burst aborts the burst. A partly written packet stays in the FIFO; it is not rolled back.

States:
- IDLE
  - If arb_en_i=1 and any req_valid_i is set, select the first valid index searching last_idx+1, last_idx+2, ... modulo NUM_REQ.
  - Register grant_o one-hot, clear the burst counter, go to BURST.
  - No write occurs in the IDLE cycle, so grant latency is 1 cycle from valid to ready.
- BURST (owner g)
  - req_ready_o[g] = fifo_full_n_i, combinational; all other readies are 0.
  - Transfer occurs when req_valid_i[g] & req_ready_o[g].
  - On a transfer: fifo_wr_o=1 and fifo_data_o=req_data_i[g] in the same cycle (combinational path, zero latency). Otherwise fifo_wr_o=0 and fifo_data_o holds its last value (registered hold mux).
  - Each transfer increments the burst counter and word_cnt_o (saturating).
  - Exit to IDLE at the next edge, setting last_idx=g and grant_o=0, when any of these holds:
    - (a) transfer with req_last_i[g]=1;
    - (b) transfer that is word number MAX_BURST of the burst;
    - (c) req_valid_i[g]=0 while fifo_full_n_i=1 (requester withdrew).
  - fifo_full_n_i=0: no transfer; stay in BURST with the counter held. Condition (c) is not evaluated while full, so a valid drop during full does not end the burst.

Boundary and corner rules:
- arb_en_i falling during BURST does not cut the burst. No new grant is issued until arb_en_i=1.
- A single requester continuously valid gets back-to-back bursts separated by exactly one IDLE cycle.
- Simultaneous last and MAX_BURST conditions produce a single exit.
- req_last_i is ignored when not qualified by a transfer.
- At most one fifo_wr_o per cycle. fifo_wr_o is never 1 while fifo_full_n_i=0.
- The burst counter is clog2(MAX_BURST)+1 bits wide and never wraps within a burst.

Test Plan:
- Round-robin: requesters 0, 1 and 2 each hold valid with 3-word packets (last on the 3rd word), FIFO not full. Expected write order is 0,0,0,1,1,1,2,2,2,0,... with one idle cycle between bursts; word_cnt_o=9 after three bursts.
- Burst cap: requester 3 alone streams 40 words with no last. Expected bursts of 16, 16 and 8, with grant_o=4'b1000 re-issued after each 1-cycle gap, and fifo_wr_o high for exactly 40 cycles.
- Full throttle: mid-burst of requester 1, drive fifo_full_n_i=0 for 5 cycles. Expected req_ready_o=0 and fifo_wr_o=0 for those 5 cycles, grant_o unchanged, and the transfer resuming on the cycle fifo_full_n_i returns to 1 with no word lost or duplicated.
- Withdraw: requester 2 is granted and sends 2 words, then drops valid with FIFO not full. Expected return to IDLE next cycle and the next grant going to requester 3 (if valid) before requester 0.
- arb_en_i: drop arb_en_i during requester 0's burst. Expected: the burst completes to last, then grant_o=0 and busy_o=0 persist while all requesters stay valid; re-raising arb_en_i grants requester 1.
- Reset mid-burst: assert mrst_n_i low between clock edges during a burst. Expected fifo_wr_o, grant_o and req_ready_o at 0 immediately and word_cnt_o=0; after release, requester 0 is granted first.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
// Write-side scheduler for the asynchronous FIFO. Shares the single FIFO
// write port among NUM_REQ requesters with round-robin burst arbitration.
// Lives entirely in the FIFO write-clock domain.
//
// Ports:
//   clk_wr_i       write clock (rising edge)
//   mrst_n_i       asynchronous active-low reset
//   arb_en_i       1 = new grants allowed; 0 = finish current burst then park
//   req_valid_i    per-requester word valid
//   req_last_i     per-requester last word of packet (qualified by transfer)
//   req_data_i     packed data, requester k at [k*DATA_WIDTH +: DATA_WIDTH]
//   req_ready_o    per-requester ready, one-hot or zero
//   fifo_full_n_i  FIFO full flag, active-low
//   fifo_wr_o      FIFO write strobe
//   fifo_data_o    FIFO write data
//   grant_o        one-hot current owner, 0 when idle
//   busy_o         1 while a burst is in progress
//   word_cnt_o     total words written since reset, saturating
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 18,
  parameter int MAX_BURST  = 16
) (
  input  logic                          clk_wr_i,
  input  logic                          mrst_n_i,
  input  logic                          arb_en_i,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  input  logic [NUM_REQ-1:0]            req_last_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  input  logic                          fifo_full_n_i,
  output logic                          fifo_wr_o,
  output logic [DATA_WIDTH-1:0]         fifo_data_o,
  output logic [NUM_REQ-1:0]            grant_o,
  output logic                          busy_o,
  output logic [15:0]                   word_cnt_o
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_BURST) + 1;

  typedef enum logic {IDLE, BURST} state_t;

  state_t                r_state;
  state_t                w_nextState;
  logic [NUM_REQ-1:0]    r_grant;
  logic [IDX_W-1:0]      r_ownerIdx;
  logic [IDX_W-1:0]      r_lastIdx;
  logic [CNT_W-1:0]      r_burstCnt;
  logic [DATA_WIDTH-1:0] r_dataHold;
  logic [15:0]           r_wordCnt;

  logic                  w_startBurst;
  logic [IDX_W-1:0]      w_pickIdx;
  logic                  w_ownValid;
  logic                  w_ownLast;
  logic [DATA_WIDTH-1:0] w_ownData;
  logic                  w_xfer;
  logic                  w_capHit;
  logic                  w_exit;

  // Search last+1, last+2, ... modulo NUM_REQ. Iterating from the farthest
  // offset down lets the nearest valid requester overwrite earlier picks.
  function automatic logic [IDX_W-1:0] rrPick(input logic [NUM_REQ-1:0] v,
                                               input logic [IDX_W-1:0]   last);
    logic [IDX_W-1:0] pick;
    int               k;
    pick = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      k = (int'(last) + i) % NUM_REQ;
      if (v[k]) pick = IDX_W'(k);
    end
    return pick;
  endfunction

  assign w_pickIdx    = rrPick(req_valid_i, r_lastIdx);
  assign w_startBurst = arb_en_i && (req_valid_i != '0);

  assign w_ownValid = req_valid_i[r_ownerIdx];
  assign w_ownLast  = req_last_i[r_ownerIdx];
  assign w_ownData  = req_data_i[r_ownerIdx*DATA_WIDTH +: DATA_WIDTH];

  assign w_xfer   = (r_state == BURST) && fifo_full_n_i && w_ownValid;
  // Current transfer would be word number MAX_BURST of this burst.
  assign w_capHit = (r_burstCnt == CNT_W'(MAX_BURST - 1));
  // Withdrawal only counts while the FIFO has space; a valid drop under
  // back-pressure keeps the burst alive.
  assign w_exit   = (r_state == BURST) &&
                    ((w_xfer && (w_ownLast || w_capHit)) ||
                     (fifo_full_n_i && !w_ownValid));

  always_ff @(posedge clk_wr_i or negedge mrst_n_i) begin
    if (!mrst_n_i) r_state <= IDLE;
    else           r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (w_startBurst) w_nextState = BURST;
      BURST:   if (w_exit)       w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_comb begin
    req_ready_o = (r_state == BURST && fifo_full_n_i) ? r_grant : '0;
    fifo_wr_o   = w_xfer;
    fifo_data_o = w_xfer ? w_ownData : r_dataHold;
    grant_o     = r_grant;
    busy_o      = (r_state == BURST);
    word_cnt_o  = r_wordCnt;
  end

  // Owner, burst bookkeeping and the data hold register.
  always_ff @(posedge clk_wr_i or negedge mrst_n_i) begin
    if (!mrst_n_i) begin
      r_grant    <= '0;
      r_ownerIdx <= '0;
      r_lastIdx  <= IDX_W'(NUM_REQ - 1);
      r_burstCnt <= '0;
      r_dataHold <= '0;
      r_wordCnt  <= '0;
    end else if (r_state == IDLE) begin
      if (w_startBurst) begin
        r_ownerIdx <= w_pickIdx;
        r_grant    <= {{(NUM_REQ-1){1'b0}}, 1'b1} << w_pickIdx;
        r_burstCnt <= '0;
      end
    end else begin
      if (w_xfer) begin
        r_burstCnt <= r_burstCnt + CNT_W'(1);
        r_dataHold <= w_ownData;
        if (r_wordCnt != 16'hFFFF) r_wordCnt <= r_wordCnt + 16'd1;
      end
      if (w_exit) begin
        r_lastIdx <= r_ownerIdx;
        r_grant   <= '0;
      end
    end
  end

endmodule
